// File: rtl/bip_multicycle_cpu.sv
// Multi-cycle BIP accumulator CPU: fetch / execute / memory-read states plus a halt state,
// with branches, run gating and a saturating retired-instruction counter.
module bip_multicycle_cpu #(
  parameter int unsigned ADDR_BITS  = 11,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_BITS   = 32,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_en,
  input  logic [DATA_WIDTH-1:0] instruction,
  output logic [ADDR_BITS-1:0]  addr_program,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  wr,
  output logic [ADDR_BITS-1:0]  addr_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DATA_WIDTH-1:0] acc,
  output logic [ADDR_BITS-1:0]  pc,
  output logic                  halted,
  output logic [CNT_BITS-1:0]   instr_count
);

  localparam int unsigned OP_BITS = DATA_WIDTH - ADDR_BITS;

  localparam logic [OP_BITS-1:0] OP_HLT  = OP_BITS'(0);
  localparam logic [OP_BITS-1:0] OP_STO  = OP_BITS'(1);
  localparam logic [OP_BITS-1:0] OP_LD   = OP_BITS'(2);
  localparam logic [OP_BITS-1:0] OP_LDI  = OP_BITS'(3);
  localparam logic [OP_BITS-1:0] OP_ADD  = OP_BITS'(4);
  localparam logic [OP_BITS-1:0] OP_ADDI = OP_BITS'(5);
  localparam logic [OP_BITS-1:0] OP_SUB  = OP_BITS'(6);
  localparam logic [OP_BITS-1:0] OP_SUBI = OP_BITS'(7);
  localparam logic [OP_BITS-1:0] OP_BEQ  = OP_BITS'(8);
  localparam logic [OP_BITS-1:0] OP_BNE  = OP_BITS'(9);
  localparam logic [OP_BITS-1:0] OP_JMP  = OP_BITS'(10);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] ir;

  logic [OP_BITS-1:0]    ex_op;
  logic [ADDR_BITS-1:0]  ex_opd;
  logic [DATA_WIDTH-1:0] ex_imm;
  logic [OP_BITS-1:0]    mem_op;
  logic [ADDR_BITS-1:0]  pc_inc;
  logic [CNT_BITS-1:0]   cnt_next;

  // In S_EXEC the fresh instruction word is decoded directly; ir serves S_MEM afterwards.
  assign ex_op    = instruction[DATA_WIDTH-1:ADDR_BITS];
  assign ex_opd   = instruction[ADDR_BITS-1:0];
  assign ex_imm   = {{OP_BITS{ex_opd[ADDR_BITS-1]}}, ex_opd};
  assign mem_op   = ir[DATA_WIDTH-1:ADDR_BITS];
  assign pc_inc   = pc + ADDR_BITS'(1);
  assign cnt_next = (&instr_count) ? instr_count : instr_count + CNT_BITS'(1);

  // Write strobe is purely state-decoded so an asynchronous reset kills it at once.
  assign wr           = (state == S_EXEC) && (ex_op == OP_STO);
  assign addr_data    = (state == S_EXEC) ? ex_opd : ir[ADDR_BITS-1:0];
  assign addr_program = pc;
  assign out_data     = acc;
  assign halted       = (state == S_HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_FETCH;
      pc          <= ADDR_BITS'(RESET_PC);
      acc         <= '0;
      ir          <= '0;
      instr_count <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (run_en) state <= S_EXEC;
        end
        S_EXEC: begin
          ir <= instruction;
          case (ex_op)
            OP_HLT: begin
              state       <= S_HALT;
              instr_count <= cnt_next;
            end
            OP_LD, OP_ADD, OP_SUB: begin
              state <= S_MEM;
            end
            default: begin
              state       <= S_FETCH;
              instr_count <= cnt_next;
              pc          <= pc_inc;
              case (ex_op)
                OP_LDI:  acc <= ex_imm;
                OP_ADDI: acc <= acc + ex_imm;
                OP_SUBI: acc <= acc - ex_imm;
                OP_BEQ:  if (acc == '0) pc <= ex_opd;
                OP_BNE:  if (acc != '0) pc <= ex_opd;
                OP_JMP:  pc <= ex_opd;
                default: ;
              endcase
            end
          endcase
        end
        S_MEM: begin
          case (mem_op)
            OP_LD:   acc <= in_data;
            OP_ADD:  acc <= acc + in_data;
            OP_SUB:  acc <= acc - in_data;
            default: ;
          endcase
          pc          <= pc_inc;
          state       <= S_FETCH;
          instr_count <= cnt_next;
        end
        S_HALT: ;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
